// File: rtl/uds_out_drain_if.sv
// Stream bundle between the up/downsample engine, the output drain and the SRAM row writer.
// The slave modport is the drain's view; the master modport is the engine-plus-sink view.
interface uds_out_drain_if #(
  parameter int unsigned A  = 64,
  parameter int unsigned DW = 32
);
  localparam int unsigned ROWS   = 2 * A / 8;
  localparam int unsigned ROW_W  = 8 * DW;
  localparam int unsigned RIDX_W = $clog2(ROWS);

  logic [2*A*DW-1:0] odata;
  logic              odata_valid;
  logic [RIDX_W:0]   cfg_rows;
  logic [ROW_W-1:0]  orow;
  logic              orow_valid;
  logic              orow_ready;
  logic [RIDX_W-1:0] orow_idx;
  logic              orow_last;
  logic              tile_done;
  logic              ovf;
  logic              ovf_clr;
  logic              busy;

  modport slave (
    input  odata, odata_valid, cfg_rows, orow_ready, ovf_clr,
    output orow, orow_valid, orow_idx, orow_last, tile_done, ovf, busy
  );

  modport master (
    output odata, odata_valid, cfg_rows, orow_ready, ovf_clr,
    input  orow, orow_valid, orow_idx, orow_last, tile_done, ovf, busy
  );
endinterface

// File: rtl/uds_out_drain.sv
// Buffers non-stallable engine tile words and serializes each into 8-item rows
// on a valid/ready stream; drops are flagged on a sticky overflow bit.
module uds_out_drain #(
  parameter int unsigned A     = 64,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  uds_out_drain_if.slave bus
);
  localparam int unsigned ROWS   = 2 * A / 8;
  localparam int unsigned ROW_W  = 8 * DW;
  localparam int unsigned RIDX_W = $clog2(ROWS);
  localparam int unsigned CFG_W  = RIDX_W + 1;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [RIDX_W-1:0] row_cnt_q, row_cnt_d;
  logic              tile_done_q, tile_done_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;

  logic [ROWS-1:0][ROW_W-1:0] mem_q  [DEPTH];
  logic [CFG_W-1:0]           rows_q [DEPTH];

  logic [CFG_W-1:0] rows_eff;
  logic             hs, last, pop, wr, drop;

  always_comb begin
    rows_eff = (bus.cfg_rows == '0 || bus.cfg_rows > CFG_W'(ROWS)) ? CFG_W'(ROWS) : bus.cfg_rows;
    hs   = (state_q == SEND) && bus.orow_ready;
    last = (state_q == SEND) && ({1'b0, row_cnt_q} == rows_q[rd_ptr_q] - CFG_W'(1));
    pop  = hs && last;
    // A full buffer still accepts a word when the final row leaves in the same cycle.
    wr   = bus.odata_valid && ((count_q < CNT_W'(DEPTH)) || pop);
    drop = bus.odata_valid && !wr;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    row_cnt_d   = row_cnt_q;
    if (hs) row_cnt_d = last ? '0 : row_cnt_q + RIDX_W'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({wr, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    ovf_d       = drop || (ovf_q && !bus.ovf_clr);
    tile_done_d = pop;
    busy_d      = (count_d != '0);
    state_d     = (count_d != '0) ? SEND : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      row_cnt_q   <= '0;
      tile_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      row_cnt_q   <= row_cnt_d;
      tile_done_q <= tile_done_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q]  <= bus.odata;
      rows_q[wr_ptr_q] <= rows_eff;
    end
  end

  always_comb begin
    bus.orow       = mem_q[rd_ptr_q][row_cnt_q];
    bus.orow_valid = (state_q == SEND);
    bus.orow_idx   = row_cnt_q;
    bus.orow_last  = last;
    bus.tile_done  = tile_done_q;
    bus.ovf        = ovf_q;
    bus.busy       = busy_q;
  end
endmodule

// File: tb/tb_uds_out_drain.sv
// Directed bench for uds_out_drain: tile serialization, short tiles, backpressure,
// overflow, full-buffer refill on the last row, and mid-tile reset.
module tb_uds_out_drain;
  localparam int unsigned A = 64, DW = 32, DEPTH = 2;
  localparam int unsigned TILE_W = 2 * A * DW, ROW_W = 8 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  uds_out_drain_if #(.A(A), .DW(DW)) bus ();

  uds_out_drain #(.A(A), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TILE_W-1:0] make_tile(input int unsigned base);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < 2 * A; k++) t[k*DW +: DW] = DW'(base + k);
    return t;
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input int unsigned base, input int unsigned r);
    logic [ROW_W-1:0] v;
    for (int unsigned j = 0; j < 8; j++) v[j*DW +: DW] = DW'(base + 8 * r + j);
    return v;
  endfunction

  task automatic send_tile(input int unsigned base, input int unsigned cfg);
    bus.odata       = make_tile(base);
    bus.cfg_rows    = 5'(cfg);
    bus.odata_valid = 1'b1;
    tick();
    bus.odata_valid = 1'b0;
  endtask

  // Consumes one tile; checks every presented row, stability under stall and the done pulse.
  task automatic recv_tile(input int unsigned base, input int unsigned n, input bit rnd);
    int unsigned r = 0;
    bit stalled = 1'b0;
    logic [ROW_W-1:0] prev_row = '0;
    logic [3:0] prev_idx = '0;
    for (int cyc = 0; cyc < 400 && r < n; cyc++) begin
      bus.orow_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("vld", 256'(bus.orow_valid), 256'(1));
      if (stalled) begin
        check("stall_row", 256'(bus.orow), 256'(prev_row));
        check("stall_idx", 256'(bus.orow_idx), 256'(prev_idx));
      end
      if (bus.orow_valid && bus.orow_ready) begin
        check("row", 256'(bus.orow), 256'(exp_row(base, r)));
        check("idx", 256'(bus.orow_idx), 256'(r));
        check("last", 256'(bus.orow_last), 256'(r == n - 1));
        r++;
        stalled = 1'b0;
      end else begin
        stalled  = bus.orow_valid;
        prev_row = bus.orow;
        prev_idx = bus.orow_idx;
      end
      tick();
    end
    bus.orow_ready = 1'b0;
    check("rows_rcvd", 256'(r), 256'(n));
    check("tile_done", 256'(bus.tile_done), 256'(1));
  endtask

  initial begin
    bus.odata = '0;
    bus.odata_valid = 1'b0;
    bus.cfg_rows = '0;
    bus.orow_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    tick();
    tick();
    check("rst_vld", 256'(bus.orow_valid), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_ovf", 256'(bus.ovf), 256'(0));
    check("rst_done", 256'(bus.tile_done), 256'(0));
    check("rst_idx", 256'(bus.orow_idx), 256'(0));
    check("rst_last", 256'(bus.orow_last), 256'(0));
    rst_n = 1'b1;
    tick();

    // Full 16-row tile, cfg_rows=0 selects all rows.
    send_tile(0, 0);
    check("lat_vld", 256'(bus.orow_valid), 256'(1));
    check("lat_idx", 256'(bus.orow_idx), 256'(0));
    recv_tile(0, 16, 1'b0);
    check("t1_idle", 256'(bus.orow_valid), 256'(0));
    check("t1_busy", 256'(bus.busy), 256'(0));
    tick();
    check("t1_done_pulse", 256'(bus.tile_done), 256'(0));

    // Short downsample tiles; an out-of-range cfg saturates to 16 rows.
    send_tile(1000, 4);
    recv_tile(1000, 4, 1'b0);
    check("t2_no_extra", 256'(bus.orow_valid), 256'(0));
    send_tile(2000, 4);
    recv_tile(2000, 4, 1'b0);
    send_tile(2500, 17);
    recv_tile(2500, 16, 1'b0);

    // Random backpressure over two queued tiles.
    send_tile(3000, 0);
    send_tile(4000, 5);
    recv_tile(3000, 16, 1'b1);
    recv_tile(4000, 5, 1'b1);

    // Overflow: third and fourth strobes dropped; a drop beats a coincident clear.
    tick();
    send_tile(5000, 2);
    send_tile(6000, 2);
    send_tile(7000, 2);
    check("ovf_set", 256'(bus.ovf), 256'(1));
    check("ovf_busy", 256'(bus.busy), 256'(1));
    bus.ovf_clr = 1'b1;
    send_tile(7500, 2);
    bus.ovf_clr = 1'b0;
    check("ovf_clr_drop", 256'(bus.ovf), 256'(1));
    recv_tile(5000, 2, 1'b0);
    recv_tile(6000, 2, 1'b0);
    check("ovf_no_third", 256'(bus.orow_valid), 256'(0));
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", 256'(bus.ovf), 256'(0));

    // Full buffer refilled in the same cycle the last row leaves.
    send_tile(8000, 2);
    send_tile(9000, 2);
    bus.orow_ready = 1'b1;
    check("t5_r0", 256'(bus.orow), 256'(exp_row(8000, 0)));
    tick();
    check("t5_last", 256'(bus.orow_last), 256'(1));
    bus.odata = make_tile(10000);
    bus.cfg_rows = 5'd2;
    bus.odata_valid = 1'b1;
    tick();
    bus.odata_valid = 1'b0;
    bus.orow_ready = 1'b0;
    check("t5_ovf", 256'(bus.ovf), 256'(0));
    check("t5_done", 256'(bus.tile_done), 256'(1));
    check("t5_b2b_vld", 256'(bus.orow_valid), 256'(1));
    check("t5_b2b_idx", 256'(bus.orow_idx), 256'(0));
    recv_tile(9000, 2, 1'b0);
    recv_tile(10000, 2, 1'b0);
    check("t5_empty", 256'(bus.busy), 256'(0));

    // Reset while row 7 is presented.
    send_tile(11000, 0);
    bus.orow_ready = 1'b1;
    for (int unsigned r = 0; r < 7; r++) tick();
    check("t6_idx7", 256'(bus.orow_idx), 256'(7));
    check("t6_row7", 256'(bus.orow), 256'(exp_row(11000, 7)));
    bus.orow_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_vld", 256'(bus.orow_valid), 256'(0));
    check("t6_busy", 256'(bus.busy), 256'(0));
    check("t6_ovf", 256'(bus.ovf), 256'(0));
    check("t6_idx", 256'(bus.orow_idx), 256'(0));
    send_tile(12000, 3);
    recv_tile(12000, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
